// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// VGA raster timing generator. The optional rgb colour-bar output is built only when VGA_TEST_PATTERN_EN is defined.
// Outputs are registered from the next position, so they add no latency. pixel_ce=0 holds all state; there is no backpressure.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL)
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          pixel_ce,
    output logic [HW-1:0] h_pos,
    output logic [VW-1:0] v_pos,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [11:0]   rgb
`endif
);

    generate
        if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_param
            $error("vga_timing_gen: every porch/sync/active parameter must be >= 1");
        end
    endgenerate

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    // Packed as {active, hsync, vsync, line_start, frame_start}
    function automatic logic [4:0] decode(input logic [HW-1:0] hh, input logic [VW-1:0] vv);
        logic act;
        logic hs;
        logic vs;
        act = (hh < H_ACT) && (vv < V_ACT);
        hs  = (hh >= H_SYNC_S && hh < H_SYNC_E) ? H_SYNC_POL : ~H_SYNC_POL;
        vs  = (vv >= V_SYNC_S && vv < V_SYNC_E) ? V_SYNC_POL : ~V_SYNC_POL;
        return {act, hs, vs, (hh == '0), (hh == '0) && (vv == '0)};
    endfunction

    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          h_wrap;
    logic [4:0]    dec_nxt;
    logic [4:0]    dec_rst;

    always_comb begin
        h_wrap  = (h_pos == H_LAST);
        h_nxt   = h_wrap ? '0 : h_pos + 1'b1;
        v_nxt   = v_pos;
        if (h_wrap) begin
            v_nxt = (v_pos == V_LAST) ? '0 : v_pos + 1'b1;
        end
        dec_nxt = decode(h_nxt, v_nxt);
        dec_rst = decode(H_LAST, V_LAST);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            h_pos <= H_LAST;
            v_pos <= V_LAST;
            {active, hsync, vsync, line_start, frame_start} <= dec_rst;
        end else if (pixel_ce) begin
            h_pos <= h_nxt;
            v_pos <= v_nxt;
            {active, hsync, vsync, line_start, frame_start} <= dec_nxt;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Eight equal-width bars across the visible line, white through black
    function automatic logic [11:0] bar_rgb(input logic [HW-1:0] hh);
        int unsigned idx;
        logic [11:0] c;
        idx = (32'(hh) * 32'd8) / 32'(H_ACTIVE);
        case (idx[2:0])
            3'd0:    c = 12'hFFF;
            3'd1:    c = 12'hFF0;
            3'd2:    c = 12'h0FF;
            3'd3:    c = 12'h0F0;
            3'd4:    c = 12'hF0F;
            3'd5:    c = 12'hF00;
            3'd6:    c = 12'h00F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= 12'h000;
        end else if (pixel_ce) begin
            rgb <= dec_nxt[4] ? bar_rgb(h_nxt) : 12'h000;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Directed bench: full-size instance for horizontal timing, a reduced raster for frame-level timing.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic pixel_ce;

    logic [9:0] d_h, d_v;
    logic       d_act, d_hs, d_vs, d_ls, d_fs;
    logic [4:0] s_h, s_v;
    logic       s_act, s_hs, s_vs, s_ls, s_fs;
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] d_rgb, s_rgb;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk_in(clk), .rst_n(rst_n), .pixel_ce(pixel_ce),
        .h_pos(d_h), .v_pos(d_v), .active(d_act), .hsync(d_hs), .vsync(d_vs),
        .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TEST_PATTERN_EN
        , .rgb(d_rgb)
`endif
    );

    // 32 x 21 raster: H 16/4/6/6, V 12/3/2/4
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_ACTIVE(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4)
    ) dut_s (
        .clk_in(clk), .rst_n(rst_n), .pixel_ce(pixel_ce),
        .h_pos(s_h), .v_pos(s_v), .active(s_act), .hsync(s_hs), .vsync(s_vs),
        .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TEST_PATTERN_EN
        , .rgb(s_rgb)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic ce);
        pixel_ce = ce;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int h_err = 0, act_err = 0, ls_err = 0, ls_cnt = 0;
        int hs_cnt = 0, hs_first = -1, hs_last = -1;
        int s_err = 0, vs_cnt = 0, vs_first = -1;
        int fs_first = -1, fs_second = -1, wrap_cnt = 0, wrap_bad = 0;
        int stall_err = 0, ls_q = 0;
        int eh, ev, sh, sv;
        logic [4:0] prev_sv;
        logic [25:0] snap;

        rst_n = 1'b0;
        pixel_ce = 1'b1;
        // Reset held with ce=1: reset must win
        repeat (3) tick(1'b1);
        check("rst_h", d_h, 799);
        check("rst_v", d_v, 524);
        check("rst_active", d_act, 0);
        check("rst_hsync", d_hs, 1);
        check("rst_vsync", d_vs, 1);
        check("rst_line_start", d_ls, 0);
        check("rst_frame_start", d_fs, 0);
        check("rst_s_h", s_h, 31);
        check("rst_s_v", s_v, 20);
`ifdef VGA_TEST_PATTERN_EN
        check("rst_rgb", d_rgb, 12'h000);
`endif

        rst_n = 1'b1;
        tick(1'b1);
        check("first_h", d_h, 0);
        check("first_v", d_v, 0);
        check("first_active", d_act, 1);
        check("first_line_start", d_ls, 1);
        check("first_frame_start", d_fs, 1);
        check("first_s_fs", s_fs, 1);
`ifdef VGA_TEST_PATTERN_EN
        check("rgb_h0", d_rgb, 12'hFFF);
`endif

        prev_sv = s_v;
        for (int k = 1; k <= 2400; k++) begin
            tick(1'b1);
            eh = k % 800;
            ev = k / 800;
            if (d_h !== 10'(eh) || d_v !== 10'(ev)) h_err++;
            if (d_act !== (eh < 640)) act_err++;
            if (d_ls !== (eh == 0)) ls_err++;
            if (d_ls === 1'b1) ls_cnt++;
            if (k < 800 && d_hs === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(d_h);
                hs_last = int'(d_h);
            end
            sh = k % 32;
            sv = (k / 32) % 21;
            if (s_h !== 5'(sh) || s_v !== 5'(sv)) s_err++;
            if (k <= 672 && s_vs === 1'b0) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = k;
            end
            if (s_fs === 1'b1) begin
                if (fs_first < 0) fs_first = k;
                else if (fs_second < 0) fs_second = k;
            end
            if (prev_sv == 5'd20 && s_v == 5'd0) begin
                wrap_cnt++;
                if (s_h !== 5'd0) wrap_bad++;
            end
            prev_sv = s_v;
`ifdef VGA_TEST_PATTERN_EN
            if (k == 80)  check("rgb_h80", d_rgb, 12'hFF0);
            if (k == 160) check("rgb_h160", d_rgb, 12'h0FF);
            if (k == 639) check("rgb_h639", d_rgb, 12'h000);
            if (k == 640) check("rgb_h640", d_rgb, 12'h000);
            if (k == 1)   check("s_rgb_h1", s_rgb, 12'hFFF);
            if (k == 2)   check("s_rgb_h2", s_rgb, 12'hFF0);
            if (k == 15)  check("s_rgb_h15", s_rgb, 12'h000);
            if (k == 16)  check("s_rgb_h16", s_rgb, 12'h000);
            if (k == 384) check("s_rgb_vact", s_rgb, 12'h000);
            if (k == 676) check("s_rgb_f2_h4", s_rgb, 12'h0FF);
`endif
        end
        check("pos_track", h_err, 0);
        check("active_window", act_err, 0);
        check("line_start_pattern", ls_err, 0);
        check("line_start_count", ls_cnt, 3);
        check("hsync_first", hs_first, 656);
        check("hsync_last", hs_last, 751);
        check("hsync_len", hs_cnt, 96);
        check("s_pos_track", s_err, 0);
        check("s_vsync_first_k", vs_first, 480);
        check("s_vsync_len", vs_cnt, 64);
        check("s_fs_first", fs_first, 672);
        check("s_fs_period", fs_second - fs_first, 672);
        check("s_wrap_cnt", wrap_cnt, 3);
        check("s_wrap_hwrap", wrap_bad, 0);

        // Sparse enable 1,0,0,1: 1600 clocks carry exactly 800 pixels
        for (int i = 0; i < 1600; i++) begin
            logic ce;
            ce = (i % 4 == 0) || (i % 4 == 3);
            snap = {d_h, d_v, d_act, d_hs, d_vs, d_ls, d_fs, s_act};
            tick(ce);
            if (!ce && snap !== {d_h, d_v, d_act, d_hs, d_vs, d_ls, d_fs, s_act}) stall_err++;
            if (ce && d_ls === 1'b1) ls_q++;
        end
        check("stall_hold", stall_err, 0);
        check("stall_h", d_h, 0);
        check("stall_v", d_v, 4);
        check("stall_line_start", d_ls, 1);
        check("stall_ls_count", ls_q, 1);

        repeat (300) tick(1'b1);
        check("mid_h", d_h, 300);
        check("mid_v", d_v, 4);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_h", d_h, 799);
        check("async_rst_v", d_v, 524);
        check("async_rst_active", d_act, 0);
        check("async_rst_hsync", d_hs, 1);
        check("async_rst_ls", d_ls, 0);
        check("async_rst_s_h", s_h, 31);
        check("async_rst_s_v", s_v, 20);
        tick(1'b1);
        check("rst_hold_h", d_h, 799);
        rst_n = 1'b1;
        tick(1'b1);
        check("rerun_h", d_h, 0);
        check("rerun_v", d_v, 0);
        check("rerun_active", d_act, 1);
        check("rerun_frame_start", d_fs, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
